// File: rtl/sdm_cic_rx.sv
// sdm_cic_rx: sigma-delta bitstream receiver with a 2nd-order CIC decimator
// feeding a small show-ahead FIFO that software drains with toggle-style pops.
module sdm_cic_rx #(
    parameter int unsigned DMSB  = 3,
    parameter int unsigned RLOG2 = 3,
    parameter int unsigned FLOG2 = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            setn,
    input  logic            fclk,
    input  logic            rx,
    input  logic            pop,
    input  logic            clear,
    output logic [DMSB:0]   rdata,
    output logic            empty,
    output logic            full,
    output logic            overrun,
    output logic [1:0]      xst
);

    localparam int unsigned W     = 2 * RLOG2 + 2;
    localparam int unsigned R     = 1 << RLOG2;
    localparam int unsigned SH    = 2 * RLOG2 - DMSB;
    localparam int unsigned DEPTH = 1 << FLOG2;
    localparam int unsigned CW    = FLOG2 + 1;
    localparam int          YMAX_I = (1 << DMSB) - 1;
    localparam int          YMIN_I = -(1 << DMSB);
    localparam logic signed [W-1:0] YMAX = W'(YMAX_I);
    localparam logic signed [W-1:0] YMIN = W'(YMIN_I);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and fclk rising-edge strobe
    // ------------------------------------------------------------------
    logic fclk_s1_q, fclk_s2_q, fclk_s3_q;
    logic rx_s1_q, rx_s2_q;
    logic stb_q;

    // Two-flop sync for fclk and rx, plus a registered edge strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fclk_s1_q <= 1'b0;
            fclk_s2_q <= 1'b0;
            fclk_s3_q <= 1'b0;
            rx_s1_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            fclk_s1_q <= fclk;
            fclk_s2_q <= fclk_s1_q;
            fclk_s3_q <= fclk_s2_q;
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            stb_q     <= fclk_s2_q & ~fclk_s3_q;
        end
    end

    // ------------------------------------------------------------------
    // CIC datapath (modular arithmetic, only the output is saturated)
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic                  disc_q, disc_d;
    logic signed [W-1:0]   i1_q, i2_q, i2z_q, c1z_q;
    logic signed [W-1:0]   x_c, i1_d, i2_d, c1_d, c2_c, sh_c;
    logic [RLOG2-1:0]      dcnt_q;
    logic [DMSB:0]         y_d, y_q;
    logic                  y_vld_q;
    logic                  dec_c;
    logic                  cic_clr_c;

    assign cic_clr_c = !setn || (state_q == ST_IDLE);
    assign dec_c     = stb_q && (dcnt_q == RLOG2'(R - 1));

    // Integrator/comb next values and the saturated, scaled output word
    always_comb begin
        x_c  = rx_s2_q ? W'(1) : {W{1'b1}};
        i1_d = i1_q + x_c;
        i2_d = i2_q + i1_d;
        c1_d = i2_d - i2z_q;
        c2_c = c1_d - c1z_q;
        sh_c = c2_c >>> SH;
        if (sh_c > YMAX) begin
            y_d = YMAX[DMSB:0];
        end else if (sh_c < YMIN) begin
            y_d = YMIN[DMSB:0];
        end else begin
            y_d = sh_c[DMSB:0];
        end
    end

    // CIC state: integrate on every strobe, comb and emit on decimation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i2z_q   <= '0;
            c1z_q   <= '0;
            dcnt_q  <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
        end else if (cic_clr_c) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i2z_q   <= '0;
            c1z_q   <= '0;
            dcnt_q  <= '0;
            y_vld_q <= 1'b0;
        end else begin
            y_vld_q <= 1'b0;
            if (stb_q) begin
                i1_q   <= i1_d;
                i2_q   <= i2_d;
                dcnt_q <= dcnt_q + RLOG2'(1);
                if (dec_c) begin
                    i2z_q   <= i2_d;
                    c1z_q   <= c1_d;
                    y_q     <= y_d;
                    y_vld_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
        end
    end

    // Next state: discard two outputs after enabling, then run
    always_comb begin
        state_d = state_q;
        disc_d  = disc_q;
        if (!setn) begin
            state_d = ST_IDLE;
            disc_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    disc_d  = 1'b0;
                end
                ST_SETTLE: begin
                    if (y_vld_q) begin
                        if (disc_q) begin
                            state_d = ST_RUN;
                        end else begin
                            disc_d = 1'b1;
                        end
                    end
                end
                ST_RUN: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign xst = state_q;

    // ------------------------------------------------------------------
    // Show-ahead FIFO with toggle pop/clear
    // ------------------------------------------------------------------
    logic [DMSB:0]      mem_q [DEPTH];
    logic [FLOG2-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               pop_q, clear_q;
    logic               ovr_q, ovr_d;
    logic               empty_q, full_q;
    logic [DMSB:0]      rdata_q, rdata_d;
    logic               pop_ev_c, clr_ev_c, flush_c, wr_req_c;
    logic               do_wr_c, do_pop_c;

    assign pop_ev_c = pop ^ pop_q;
    assign clr_ev_c = clear ^ clear_q;
    assign flush_c  = !setn || clr_ev_c;
    assign wr_req_c = y_vld_q && (state_q == ST_RUN);

    // FIFO next state; flush beats write and pop, pop on empty is ignored
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        ovr_d    = ovr_q;
        rdata_d  = rdata_q;
        do_wr_c  = 1'b0;
        do_pop_c = 1'b0;
        if (flush_c) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovr_d  = 1'b0;
        end else begin
            do_pop_c = pop_ev_c && (cnt_q != '0);
            if (wr_req_c) begin
                if ((cnt_q != CW'(DEPTH)) || do_pop_c) begin
                    do_wr_c = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            if (do_pop_c) begin
                rptr_d = rptr_q + FLOG2'(1);
            end
            if (do_wr_c) begin
                wptr_d = wptr_q + FLOG2'(1);
            end
            cnt_d = cnt_q + CW'(do_wr_c) - CW'(do_pop_c);
            if (cnt_d != '0) begin
                if (do_wr_c && (rptr_d == wptr_q)) begin
                    rdata_d = y_q;
                end else begin
                    rdata_d = mem_q[rptr_d];
                end
            end
        end
    end

    // FIFO storage (no reset needed, guarded by the count)
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wptr_q] <= y_q;
        end
    end

    // FIFO pointers, flags and toggle trackers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            rdata_q <= '0;
            pop_q   <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CW'(DEPTH));
            rdata_q <= rdata_d;
            pop_q   <= pop;
            clear_q <= clear;
        end
    end

    assign rdata   = rdata_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_sdm_cic_rx.sv
// tb_sdm_cic_rx: bench for sdm_cic_rx with a full-precision CIC model whose
// output words are queued as the expected FIFO contents.
module tb_sdm_cic_rx;

    logic       clk, rstn, setn, fclk, rx, pop, clear;
    logic [3:0] rdata;
    logic       empty, full, overrun;
    logic [1:0] xst;

    sdm_cic_rx dut (
        .clk(clk), .rstn(rstn), .setn(setn), .fclk(fclk), .rx(rx),
        .pop(pop), .clear(clear), .rdata(rdata), .empty(empty),
        .full(full), .overrun(overrun), .xst(xst)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    int         m_i1, m_i2, m_i2z, m_c1z, m_dc, m_disc;
    bit         m_idle, m_ovr;
    logic [3:0] m_rd;
    logic [3:0] fq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_state(input string tag);
        logic [1:0] ex;
        ex = m_idle ? 2'd0 : ((m_disc < 2) ? 2'd1 : 2'd2);
        check({tag, "/xst"},   32'(xst),     32'(ex));
        check({tag, "/empty"}, 32'(empty),   32'(fq.size() == 0));
        check({tag, "/full"},  32'(full),    32'(fq.size() == 4));
        check({tag, "/ovr"},   32'(overrun), 32'(m_ovr));
        check({tag, "/rdata"}, 32'(rdata),   32'(m_rd));
    endtask

    function automatic logic [3:0] sat(input int v);
        int s;
        s = v / 8;
        if (s * 8 > v) s = s - 1;   // floor division
        if (s > 7) s = 7;
        if (s < -8) s = -8;
        return 4'(s);
    endfunction

    task automatic model_cic_zero();
        m_i1 = 0; m_i2 = 0; m_i2z = 0; m_c1z = 0; m_dc = 0; m_disc = 0;
    endtask

    task automatic model_pop();
        if (fq.size() > 0) begin
            void'(fq.pop_front());
            if (fq.size() > 0) m_rd = fq[0];
        end
    endtask

    task automatic model_step(input bit b);
        int c1, c2;
        logic [3:0] y;
        m_i1 += b ? 1 : -1;
        m_i2 += m_i1;
        m_dc++;
        if (m_dc == 8) begin
            m_dc  = 0;
            c1    = m_i2 - m_i2z;
            m_i2z = m_i2;
            c2    = c1 - m_c1z;
            m_c1z = c1;
            y     = sat(c2);
            if (m_disc < 2) m_disc++;
            else if (fq.size() < 4) begin
                if (fq.size() == 0) m_rd = y;
                fq.push_back(y);
            end else m_ovr = 1;
        end
    endtask

    // One modulator bit; optionally toggle pop so it lands with the FIFO write
    task automatic fbit(input bit b, input bit pop_at_wr);
        @(negedge clk);
        rx = b; fclk = 1'b1;
        repeat (4) @(negedge clk);
        if (pop_at_wr) begin
            pop = ~pop;
            model_pop();
        end
        model_step(b);
        repeat (4) @(negedge clk);
        fclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_bits(input int n, input bit b, input string tag);
        for (int i = 0; i < n; i++) begin
            fbit(b, 1'b0);
            check_state(tag);
        end
    endtask

    task automatic do_pop(input string tag);
        @(negedge clk);
        pop = ~pop;
        model_pop();
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = ~clear;
        fq.delete(); m_ovr = 0;
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic stop_run(input string tag);
        @(negedge clk);
        setn = 1'b0;
        m_idle = 1; model_cic_zero(); fq.delete(); m_ovr = 0;
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic start_run(input string tag);
        @(negedge clk);
        setn = 1'b1;
        m_idle = 0; model_cic_zero();
        repeat (2) @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        clk = 0; rstn = 0; setn = 0; fclk = 0; rx = 0; pop = 0; clear = 0;
        m_idle = 1; m_ovr = 0; m_rd = 4'd0; model_cic_zero();
        repeat (3) @(negedge clk);
        check_state("reset");
        rstn = 1;
        @(negedge clk);

        // 1: constant +1
        start_run("t1_start");
        run_bits(24, 1'b1, "t1");
        check("t1_first_word", 32'(rdata), 32'd7);
        check("t1_run", 32'(xst), 32'd2);

        // 2: constant -1, then alternating bits
        stop_run("t2_stop");
        start_run("t2_start");
        run_bits(32, 1'b0, "t2_neg");
        check("t2_neg_word", 32'(rdata), 32'h8);
        while (fq.size() > 0) do_pop("t2_drain");
        stop_run("t2_stop2");
        start_run("t2_start2");
        for (int i = 0; i < 40; i++) begin
            fbit(1'(i % 2), 1'b0);
            check_state("t2_alt");
        end
        check("t2_alt_word", 32'(rdata), 32'h0);

        // 3: fill, overrun, clear, pop on empty
        stop_run("t3_stop");
        start_run("t3_start");
        run_bits(56, 1'b1, "t3");
        check("t3_full", 32'(full), 32'd1);
        check("t3_ovr", 32'(overrun), 32'd1);
        check("t3_rdata", 32'(rdata), 32'd7);
        do_clear("t3_clear");
        check("t3_clr_empty", 32'(empty), 32'd1);
        do_pop("t3_pop_empty");

        // 4: pop coincident with a write while full
        run_bits(8, 1'b1, "t4_fill1");
        run_bits(24, 1'b0, "t4_fill0");
        check("t4_full_before", 32'(full), 32'd1);
        run_bits(7, 1'b0, "t4_pre");
        fbit(1'b0, 1'b1);
        check_state("t4_popwr");
        check("t4_full_after", 32'(full), 32'd1);
        check("t4_no_ovr", 32'(overrun), 32'd0);
        check("t4_rdata_adv", 32'(rdata), 32'hf);

        // 5: disable with 3 words stored, re-enable
        do_pop("t5_pop");
        check("t5_three", 32'(fq.size()), 32'd3);
        stop_run("t5_stop");
        start_run("t5_start");
        run_bits(16, 1'b1, "t5_settle");
        run_bits(8, 1'b1, "t5_run");
        check("t5_word", 32'(rdata), 32'd7);

        // 6: asynchronous reset mid-decimation
        run_bits(3, 1'b1, "t6_pre");
        @(negedge clk);
        rx = 1'b1; fclk = 1'b1;
        repeat (2) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("t6_rdata", 32'(rdata), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_full", 32'(full), 32'd0);
        check("t6_ovr", 32'(overrun), 32'd0);
        check("t6_xst", 32'(xst), 32'd0);
        fclk = 1'b0; setn = 1'b0;
        m_idle = 1; model_cic_zero(); fq.delete(); m_ovr = 0; m_rd = 4'd0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_state("t6_after");
        start_run("t6_start");
        run_bits(24, 1'b1, "t6_run");
        check("t6_word", 32'(rdata), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
